// File: rtl/cache_tag_array_nway.sv
`default_nettype none
// ============================================================================
// Module   : cache_tag_array_nway
// Purpose  : N-way set-associative tag store with a synchronous read and a
//            built-in hit check. It chooses fill victims: the first invalid
//            way, otherwise a round-robin way kept per set. It also runs its
//            own power-up initialisation and flush sweeps.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   lookup_valid/ready    lookup handshake; lookup_index/lookup_tag probe
//   rsp_valid             response strobe, one cycle after lookup acceptance
//   rsp_hit/way/multi     hit flag, one-hot matching ways, >1 match error
//                         (these hold their values while rsp_valid is low)
//   fill_valid/ready      fill handshake; fill_index/fill_tag to install
//   fill_way              one-hot victim way for the fill presented now
//   flush                 invalidate-all pulse (ignored while busy)
//   busy                  initialisation or flush sweep in progress
// ============================================================================
module cache_tag_array_nway #(
  parameter int WAYS      = 2,
  parameter int IDX_WIDTH = 3,
  parameter int TAG_WIDTH = 14
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 lookup_valid,
  input  logic [IDX_WIDTH-1:0] lookup_index,
  input  logic [TAG_WIDTH-1:0] lookup_tag,
  output logic                 lookup_ready,
  output logic                 rsp_valid,
  output logic                 rsp_hit,
  output logic [WAYS-1:0]      rsp_way,
  output logic                 rsp_multi,
  input  logic                 fill_valid,
  input  logic [IDX_WIDTH-1:0] fill_index,
  input  logic [TAG_WIDTH-1:0] fill_tag,
  output logic                 fill_ready,
  output logic [WAYS-1:0]      fill_way,
  input  logic                 flush,
  output logic                 busy
);

  localparam int DEPTH = 1 << IDX_WIDTH;
  localparam int RR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [1:0] c_INIT  = 2'd0;
  localparam logic [1:0] c_IDLE  = 2'd1;
  localparam logic [1:0] c_FLUSH = 2'd2;

  localparam logic [IDX_WIDTH-1:0] c_LAST_SET = IDX_WIDTH'(DEPTH - 1);
  localparam logic [RR_W-1:0]      c_LAST_WAY = RR_W'(WAYS - 1);

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [IDX_WIDTH-1:0] r_clr;
  logic                 w_sweep;
  logic                 w_fill_acc;
  logic                 w_lookup_acc;

  // The clear counter naturally wraps to zero after the last set, which is
  // exactly the value it must hold when the sweep ends.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_INIT;
      r_clr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_clr   <= w_sweep ? r_clr + 1'b1 : '0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_INIT, c_FLUSH: if (r_clr == c_LAST_SET) w_state_nxt = c_IDLE;
      c_IDLE:          if (flush) w_state_nxt = c_FLUSH;
      default:         w_state_nxt = c_INIT;
    endcase
  end

  // Flush wins over any same-cycle request; a fill owns the array port, so a
  // lookup is only taken when no fill is presented.
  always_comb begin
    w_sweep      = 1'b0;
    busy         = 1'b1;
    fill_ready   = 1'b0;
    lookup_ready = 1'b0;
    case (r_state)
      c_INIT, c_FLUSH: w_sweep = 1'b1;
      c_IDLE: begin
        busy         = 1'b0;
        fill_ready   = !flush;
        lookup_ready = !flush && !fill_valid;
      end
      default: ;
    endcase
    w_fill_acc   = fill_valid && fill_ready;
    w_lookup_acc = lookup_valid && lookup_ready;
  end

  // --------------------------------------------------------------------------
  // Valid shadow and victim selection
  // --------------------------------------------------------------------------
  logic [WAYS-1:0] r_vld [DEPTH];
  logic [RR_W-1:0] r_rr  [DEPTH];
  logic [WAYS-1:0] w_vset;
  logic            w_found;
  logic [RR_W-1:0] w_vic;

  assign w_vset = r_vld[fill_index];

  always_comb begin
    w_found = 1'b0;
    w_vic   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!w_found && !w_vset[w]) begin
        w_found = 1'b1;
        w_vic   = RR_W'(w);
      end
    end
    if (!w_found) w_vic = r_rr[fill_index];
  end

  always_comb begin
    fill_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      fill_way[w] = (w_vic == RR_W'(w));
    end
  end

  always_ff @(posedge clock) begin
    if (w_sweep) begin
      r_vld[r_clr] <= '0;
    end else if (w_fill_acc) begin
      r_vld[fill_index] <= r_vld[fill_index] | fill_way;
    end
  end

  // The pointer only advances when a valid way is evicted. With one way the
  // last-way constant is zero, so the pointer stays at zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_rr[i] <= '0;
    end else if (w_fill_acc && !w_found) begin
      r_rr[fill_index] <= (r_rr[fill_index] == c_LAST_WAY) ? '0
                                                           : r_rr[fill_index] + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Tag arrays: {valid, tag} per way, read through a latched index
  // --------------------------------------------------------------------------
  logic [IDX_WIDTH-1:0] r_rd_idx;
  logic [TAG_WIDTH-1:0] r_tag;
  logic [WAYS-1:0]      w_match;

  always_ff @(posedge clock) begin
    if (w_lookup_acc) begin
      r_rd_idx <= lookup_index;
      r_tag    <= lookup_tag;
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic [TAG_WIDTH:0] r_mem [DEPTH];
    logic [TAG_WIDTH:0] w_rd;

    always_ff @(posedge clock) begin
      if (w_sweep) begin
        r_mem[r_clr] <= '0;
      end else if (w_fill_acc && fill_way[w]) begin
        r_mem[fill_index] <= {1'b1, fill_tag};
      end
    end

    assign w_rd       = r_mem[r_rd_idx];
    assign w_match[w] = w_rd[TAG_WIDTH] && (w_rd[TAG_WIDTH-1:0] == r_tag);
  end

  // --------------------------------------------------------------------------
  // Response: live compare in the strobe cycle, held copy otherwise
  // --------------------------------------------------------------------------
  logic            r_rsp_valid;
  logic            r_hit_hold;
  logic [WAYS-1:0] r_way_hold;
  logic            r_multi_hold;
  logic            w_multi;

  // More than one bit set <=> clearing the lowest set bit leaves something.
  assign w_multi = |(w_match & (w_match - 1'b1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid  <= 1'b0;
      r_hit_hold   <= 1'b0;
      r_way_hold   <= '0;
      r_multi_hold <= 1'b0;
    end else begin
      r_rsp_valid <= w_lookup_acc;
      if (r_rsp_valid) begin
        r_hit_hold   <= |w_match;
        r_way_hold   <= w_match;
        r_multi_hold <= w_multi;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_hit   = r_rsp_valid ? |w_match : r_hit_hold;
  assign rsp_way   = r_rsp_valid ? w_match  : r_way_hold;
  assign rsp_multi = r_rsp_valid ? w_multi  : r_multi_hold;

endmodule
`default_nettype wire

// File: tb/tb_cache_tag_array_nway.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_tag_array_nway
// Purpose  : Directed self-checking bench for cache_tag_array_nway with its
//            default parameters (2 ways, 8 sets, 14-bit tags).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_tag_array_nway;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        lookup_valid = 1'b0;
  logic [2:0]  lookup_index = '0;
  logic [13:0] lookup_tag = '0;
  logic        lookup_ready;
  logic        rsp_valid;
  logic        rsp_hit;
  logic [1:0]  rsp_way;
  logic        rsp_multi;
  logic        fill_valid = 1'b0;
  logic [2:0]  fill_index = '0;
  logic [13:0] fill_tag = '0;
  logic        fill_ready;
  logic [1:0]  fill_way;
  logic        flush = 1'b0;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;

  cache_tag_array_nway #(.WAYS(2), .IDX_WIDTH(3), .TAG_WIDTH(14)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .lookup_valid (lookup_valid),
    .lookup_index (lookup_index),
    .lookup_tag   (lookup_tag),
    .lookup_ready (lookup_ready),
    .rsp_valid    (rsp_valid),
    .rsp_hit      (rsp_hit),
    .rsp_way      (rsp_way),
    .rsp_multi    (rsp_multi),
    .fill_valid   (fill_valid),
    .fill_index   (fill_index),
    .fill_tag     (fill_tag),
    .fill_ready   (fill_ready),
    .fill_way     (fill_way),
    .flush        (flush),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Bounded wait for the end of a sweep; returns the number of busy cycles.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic do_fill(input logic [2:0] idx, input logic [13:0] tag,
                         output logic [1:0] way);
    fill_valid = 1'b1;
    fill_index = idx;
    fill_tag   = tag;
    #1;
    way = fill_way;
    tick();
    fill_valid = 1'b0;
  endtask

  task automatic do_lookup(input logic [2:0] idx, input logic [13:0] tag,
                           output logic v, output logic h,
                           output logic [1:0] w, output logic m);
    lookup_valid = 1'b1;
    lookup_index = idx;
    lookup_tag   = tag;
    tick();
    lookup_valid = 1'b0;
    v = rsp_valid;
    h = rsp_hit;
    w = rsp_way;
    m = rsp_multi;
  endtask

  task automatic test_reset();
    int n;
    tick();
    tick();
    n_total++; if (busy !== 1'b1) $display("FAIL rst_busy: got %b want 1", busy); else n_pass++;
    n_total++; if (lookup_ready !== 1'b0) $display("FAIL rst_lookup_ready: got %b want 0", lookup_ready); else n_pass++;
    n_total++; if (fill_ready !== 1'b0) $display("FAIL rst_fill_ready: got %b want 0", fill_ready); else n_pass++;
    n_total++; if ({rsp_valid, rsp_hit, rsp_way, rsp_multi} !== 5'b0) $display("FAIL rst_rsp: got %b want 00000", {rsp_valid, rsp_hit, rsp_way, rsp_multi}); else n_pass++;
    reset_n = 1'b1;
    wait_idle(n);
    n_total++; if (n !== 8) $display("FAIL init_cycles: got %0d want 8", n); else n_pass++;
    n_total++; if (lookup_ready !== 1'b1) $display("FAIL idle_lookup_ready: got %b want 1", lookup_ready); else n_pass++;
  endtask

  task automatic test_lookup_miss();
    logic v, h, m;
    logic [1:0] w;
    do_lookup(3'd5, 14'h0000, v, h, w, m);
    n_total++; if ({v, h, w} !== 4'b1000) $display("FAIL miss_rsp: got v%b h%b w%b want v1 h0 w00", v, h, w); else n_pass++;
    tick();
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL rsp_valid_drop: got %b want 0", rsp_valid); else n_pass++;
  endtask

  task automatic test_fill_hit();
    logic v, h, m;
    logic [1:0] w;
    do_fill(3'd3, 14'h1A5, w);
    n_total++; if (w !== 2'b01) $display("FAIL fill_way_first: got %b want 01", w); else n_pass++;
    do_lookup(3'd3, 14'h1A5, v, h, w, m);
    n_total++; if ({v, h, w, m} !== 5'b11010) $display("FAIL fill_hit: got v%b h%b w%b m%b want v1 h1 w01 m0", v, h, w, m); else n_pass++;
    do_lookup(3'd3, 14'h1A6, v, h, w, m);
    n_total++; if ({v, h, w} !== 4'b1000) $display("FAIL near_tag_miss: got v%b h%b w%b want v1 h0 w00", v, h, w); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic v, h, m;
    logic [1:0] w;
    do_fill(3'd6, 14'h1A5, w);
    n_total++; if (w !== 2'b01) $display("FAIL rr_fill1: got %b want 01", w); else n_pass++;
    do_fill(3'd6, 14'h02B, w);
    n_total++; if (w !== 2'b10) $display("FAIL rr_fill2: got %b want 10", w); else n_pass++;
    do_fill(3'd6, 14'h03C, w);
    n_total++; if (w !== 2'b01) $display("FAIL rr_fill3: got %b want 01", w); else n_pass++;
    do_lookup(3'd6, 14'h1A5, v, h, w, m);
    n_total++; if ({v, h, w} !== 4'b1000) $display("FAIL rr_evicted_miss: got v%b h%b w%b want v1 h0 w00", v, h, w); else n_pass++;
    do_lookup(3'd6, 14'h03C, v, h, w, m);
    n_total++; if ({h, w} !== 3'b101) $display("FAIL rr_hit_03c: got h%b w%b want h1 w01", h, w); else n_pass++;
    do_lookup(3'd6, 14'h02B, v, h, w, m);
    n_total++; if ({h, w} !== 3'b110) $display("FAIL rr_hit_02b: got h%b w%b want h1 w10", h, w); else n_pass++;
    // rr[6] is now 1: the next eviction takes way 1 and the pointer wraps.
    do_fill(3'd6, 14'h044, w);
    n_total++; if (w !== 2'b10) $display("FAIL rr_fill4: got %b want 10", w); else n_pass++;
    do_fill(3'd6, 14'h055, w);
    n_total++; if (w !== 2'b01) $display("FAIL rr_wrap: got %b want 01", w); else n_pass++;
  endtask

  task automatic test_fill_lookup_conflict();
    fill_valid   = 1'b1; fill_index = 3'd2; fill_tag = 14'h155;
    lookup_valid = 1'b1; lookup_index = 3'd2; lookup_tag = 14'h155;
    #1;
    n_total++; if ({fill_ready, lookup_ready} !== 2'b10) $display("FAIL conflict_ready: got fr%b lr%b want fr1 lr0", fill_ready, lookup_ready); else n_pass++;
    n_total++; if (fill_way !== 2'b01) $display("FAIL conflict_fill_way: got %b want 01", fill_way); else n_pass++;
    tick();
    fill_valid = 1'b0;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL conflict_no_rsp: got %b want 0", rsp_valid); else n_pass++;
    tick();
    lookup_valid = 1'b0;
    n_total++; if ({rsp_valid, rsp_hit, rsp_way} !== 4'b1101) $display("FAIL retry_hit: got v%b h%b w%b want v1 h1 w01", rsp_valid, rsp_hit, rsp_way); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic v, h, m;
    logic [1:0] w;
    do_lookup(3'd2, 14'h155, v, h, w, m);
    n_total++; if ({v, h, w} !== 4'b1101) $display("FAIL b2b_0: got v%b h%b w%b want v1 h1 w01", v, h, w); else n_pass++;
    do_lookup(3'd5, 14'h0000, v, h, w, m);
    n_total++; if ({v, h, w} !== 4'b1000) $display("FAIL b2b_1: got v%b h%b w%b want v1 h0 w00", v, h, w); else n_pass++;
    do_lookup(3'd6, 14'h044, v, h, w, m);
    n_total++; if ({v, h, w} !== 4'b1110) $display("FAIL b2b_2: got v%b h%b w%b want v1 h1 w10", v, h, w); else n_pass++;
    tick();
    n_total++; if ({rsp_valid, rsp_hit, rsp_way, rsp_multi} !== 5'b01100) $display("FAIL rsp_hold: got v%b h%b w%b m%b want v0 h1 w10 m0", rsp_valid, rsp_hit, rsp_way, rsp_multi); else n_pass++;
  endtask

  task automatic test_flush();
    logic v, h, m;
    logic [1:0] w;
    int n;
    logic [2:0]  idx_tbl [4] = '{3'd0, 3'd1, 3'd4, 3'd7};
    logic [13:0] tag_tbl [4] = '{14'h100, 14'h101, 14'h104, 14'h107};
    for (int i = 0; i < 4; i++) do_fill(idx_tbl[i], tag_tbl[i], w);
    flush = 1'b1;
    fill_valid = 1'b1; fill_index = 3'd5; fill_tag = 14'h0AA;
    lookup_valid = 1'b1; lookup_index = 3'd0; lookup_tag = 14'h100;
    #1;
    n_total++; if ({fill_ready, lookup_ready} !== 2'b00) $display("FAIL flush_priority: got fr%b lr%b want fr0 lr0", fill_ready, lookup_ready); else n_pass++;
    tick();
    flush = 1'b0; fill_valid = 1'b0; lookup_valid = 1'b0;
    n_total++; if ({busy, rsp_valid} !== 2'b10) $display("FAIL flush_start: got busy%b v%b want busy1 v0", busy, rsp_valid); else n_pass++;
    n = 0;
    while (busy && n < 40) begin
      flush = (n == 3);
      tick();
      n++;
    end
    flush = 1'b0;
    n_total++; if (n !== 8) $display("FAIL flush_cycles: got %0d want 8", n); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      do_lookup(idx_tbl[i], tag_tbl[i], v, h, w, m);
      n_total++; if ({v, h, w} !== 4'b1000) $display("FAIL flush_miss_%0d: got v%b h%b w%b want v1 h0 w00", i, v, h, w); else n_pass++;
    end
    do_lookup(3'd5, 14'h0AA, v, h, w, m);
    n_total++; if (h !== 1'b0) $display("FAIL flush_blocked_fill: got h%b want h0", h); else n_pass++;
    do_fill(3'd6, 14'h777, w);
    n_total++; if (w !== 2'b01) $display("FAIL flush_refill6: got %b want 01", w); else n_pass++;
    do_fill(3'd2, 14'h222, w);
    n_total++; if (w !== 2'b01) $display("FAIL flush_refill2: got %b want 01", w); else n_pass++;
  endtask

  task automatic test_reset_mid_sweep();
    logic v, h, m;
    logic [1:0] w;
    int n;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    n_total++; if ({busy, lookup_ready, rsp_valid} !== 3'b100) $display("FAIL init_reset: got busy%b lr%b v%b want busy1 lr0 v0", busy, lookup_ready, rsp_valid); else n_pass++;
    tick();
    reset_n = 1'b1;
    wait_idle(n);
    n_total++; if (n !== 8) $display("FAIL init_restart_cycles: got %0d want 8", n); else n_pass++;
    do_fill(3'd3, 14'h333, w);
    do_lookup(3'd3, 14'h333, v, h, w, m);
    n_total++; if ({h, w} !== 3'b101) $display("FAIL pre_flush_hit: got h%b w%b want h1 w01", h, w); else n_pass++;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    n_total++; if ({busy, fill_ready, rsp_valid, rsp_hit, rsp_way, rsp_multi} !== 7'b1000000) $display("FAIL flush_reset: got busy%b fr%b v%b h%b w%b m%b want busy1 fr0 v0 h0 w00 m0", busy, fill_ready, rsp_valid, rsp_hit, rsp_way, rsp_multi); else n_pass++;
    tick();
    reset_n = 1'b1;
    wait_idle(n);
    n_total++; if (n !== 8) $display("FAIL flush_reset_cycles: got %0d want 8", n); else n_pass++;
    do_lookup(3'd3, 14'h333, v, h, w, m);
    n_total++; if ({v, h, w} !== 4'b1000) $display("FAIL post_reset_miss: got v%b h%b w%b want v1 h0 w00", v, h, w); else n_pass++;
  endtask

  task automatic test_duplicate();
    logic v, h, m;
    logic [1:0] w;
    do_fill(3'd1, 14'h2222, w);
    n_total++; if (w !== 2'b01) $display("FAIL dup_fill1: got %b want 01", w); else n_pass++;
    do_fill(3'd1, 14'h2222, w);
    n_total++; if (w !== 2'b10) $display("FAIL dup_fill2: got %b want 10", w); else n_pass++;
    do_lookup(3'd1, 14'h2222, v, h, w, m);
    n_total++; if ({v, h, w, m} !== 5'b11111) $display("FAIL dup_multi: got v%b h%b w%b m%b want v1 h1 w11 m1", v, h, w, m); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_lookup_miss();
    test_fill_hit();
    test_round_robin();
    test_fill_lookup_conflict();
    test_back_to_back();
    test_flush();
    test_reset_mid_sweep();
    test_duplicate();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
